// File: rtl/rw_trace_fifo.sv
// Write-back trace FIFO: captures committed register writes, tags them with a
// sequence number (when RW_TRACE_SEQ_EN is defined) and drops on overflow without stalling.
module rw_trace_fifo #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32,
  parameter int SEQ_W  = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wb_en,
  input  logic [ADDR_W-1:0]      wb_addr,
  input  logic [DATA_W-1:0]      wb_data,
  output logic                   trace_valid,
  input  logic                   trace_ready,
  output logic [ADDR_W-1:0]      trace_addr,
  output logic [DATA_W-1:0]      trace_data,
  output logic [SEQ_W-1:0]       trace_seq,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty,
  output logic [15:0]            drop_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [15:0]      DROP_MAX = '1;

  logic [ADDR_W-1:0] mem_addr_q [DEPTH];
  logic [DATA_W-1:0] mem_data_q [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [15:0]      drop_cnt_q, drop_cnt_d;

  logic empty_w, full_w, pop, push_ok;

`ifdef RW_TRACE_SEQ_EN
  logic [SEQ_W-1:0] mem_seq_q [DEPTH];
  logic [SEQ_W-1:0] seq_ctr_q, seq_ctr_d;
`endif

  always_comb begin
    empty_w = (count_q == '0);
    full_w  = (count_q == FULL_CNT);
    pop     = ~empty_w & trace_ready;
    // A full FIFO still accepts when the head leaves in the same cycle.
    push_ok = wb_en & (~full_w | pop);
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    drop_cnt_d = drop_cnt_q;

    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)     rd_ptr_d = rd_ptr_q + PTR_W'(1);

    unique case ({push_ok, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    if (wb_en && !push_ok && (drop_cnt_q != DROP_MAX))
      drop_cnt_d = drop_cnt_q + 16'd1;
  end

`ifdef RW_TRACE_SEQ_EN
  // Counts every attempted push so dropped writes leave gaps in trace_seq.
  always_comb begin
    seq_ctr_d = seq_ctr_q;
    if (wb_en) seq_ctr_d = seq_ctr_q + SEQ_W'(1);
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      drop_cnt_q <= '0;
`ifdef RW_TRACE_SEQ_EN
      seq_ctr_q  <= '0;
`endif
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      drop_cnt_q <= drop_cnt_d;
`ifdef RW_TRACE_SEQ_EN
      seq_ctr_q  <= seq_ctr_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push_ok) begin
      mem_addr_q[wr_ptr_q] <= wb_addr;
      mem_data_q[wr_ptr_q] <= wb_data;
`ifdef RW_TRACE_SEQ_EN
      mem_seq_q[wr_ptr_q]  <= seq_ctr_q;
`endif
    end
  end

  always_comb begin
    trace_valid = ~empty_w;
    trace_addr  = empty_w ? '0 : mem_addr_q[rd_ptr_q];
    trace_data  = empty_w ? '0 : mem_data_q[rd_ptr_q];
`ifdef RW_TRACE_SEQ_EN
    trace_seq   = empty_w ? '0 : mem_seq_q[rd_ptr_q];
`else
    trace_seq   = '0;
`endif
    count       = count_q;
    full        = full_w;
    empty       = empty_w;
    drop_cnt    = drop_cnt_q;
  end

endmodule
